// File: rtl/uart_word_tx.sv
// uart_word_tx: UART 8N1 transmitter fed by a word FIFO; each 32-bit word goes out as 4 bytes, LSB byte first.
// tx_o is registered; the bit period is latched from clks_per_bit_i at every START entry.
module uart_word_tx #(
    parameter int FifoDepth = 4,
    localparam int CW = $clog2(FifoDepth) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [14:0]   clks_per_bit_i,
    input  logic          word_valid_i,
    output logic          word_ready_o,
    input  logic [31:0]   word_data_i,
    output logic          tx_o,
    output logic          busy_o,
    output logic [CW-1:0] fifo_count_o,
    output logic          byte_done_o,
    output logic          word_done_o
);
    localparam int AW = $clog2(FifoDepth);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
    state_e        state_q, state_d;
    logic [31:0]   mem_q [FifoDepth];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;
    logic [31:0]   word_q, word_d;
    logic [1:0]    byte_q, byte_d;
    logic [2:0]    bit_q, bit_d;
    logic [14:0]   p_q, p_d, baud_q, baud_d, p_new;
    logic          tx_q, tx_d, push, pop, last;

    assign p_new        = (clks_per_bit_i < 15'd2) ? 15'd2 : clks_per_bit_i;
    assign last         = baud_q == p_q - 15'd1;
    assign word_ready_o = count_q != CW'(FifoDepth);
    assign push         = word_valid_i && word_ready_o;
    assign tx_o         = tx_q;
    assign busy_o       = state_q != IDLE;
    assign fifo_count_o = count_q;

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        byte_d      = byte_q;
        bit_d       = bit_q;
        p_d         = p_q;
        baud_d      = last ? '0 : baud_q + 15'd1;
        byte_done_o = 1'b0;
        word_done_o = 1'b0;
        case (state_q)
            START: if (last) begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA: if (last) begin
                bit_d = bit_q + 3'd1;
                if (bit_q == 3'd7) state_d = STOP;
            end
            STOP: if (last) begin
                byte_done_o = 1'b1;
                word_done_o = byte_q == 2'd3;
                state_d     = IDLE;
                if (byte_q != 2'd3) begin
                    byte_d  = byte_q + 2'd1;
                    p_d     = p_new;
                    state_d = START;
                end
            end
            default: ;
        endcase
        // a new word starts from IDLE or straight out of the final STOP bit, with no gap
        pop = (count_q != '0) && (state_q == IDLE || word_done_o);
        if (pop) begin
            word_d  = mem_q[rd_q];
            byte_d  = '0;
            p_d     = p_new;
            baud_d  = '0;
            state_d = START;
        end
        tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? word_d[{byte_d, bit_d}] : 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            word_q  <= '0;
            byte_q  <= '0;
            bit_q   <= '0;
            p_q     <= 15'd2;
            baud_q  <= '0;
            tx_q    <= 1'b1;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            p_q     <= p_d;
            baud_q  <= baud_d;
            tx_q    <= tx_d;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_q] <= word_data_i;
    end
endmodule

// File: tb/tb_uart_word_tx.sv
// tb_uart_word_tx: directed and random stimulus against a per-cycle model of the expected serial stream.
module tb_uart_word_tx;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [14:0] cpb = 15'd4;
    logic        word_valid_i = 1'b0;
    logic        word_ready_o;
    logic [31:0] word_data_i = '0;
    logic        tx_o, busy_o, byte_done_o, word_done_o;
    logic [2:0]  fifo_count_o;

    uart_word_tx #(.FifoDepth(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clks_per_bit_i(cpb),
        .word_valid_i(word_valid_i), .word_ready_o(word_ready_o), .word_data_i(word_data_i),
        .tx_o(tx_o), .busy_o(busy_o), .fifo_count_o(fifo_count_o),
        .byte_done_o(byte_done_o), .word_done_o(word_done_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0, fails = 0;
    int busy_cyc, bd_cnt, wd_cnt, acc;
    logic [31:0] mq[$];
    logic        sq[$];
    logic [31:0] cur_w;
    int          left = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void gen_byte(input logic [7:0] b);
        int p = (cpb < 15'd2) ? 2 : int'(cpb);
        logic [9:0] f = {1'b1, b, 1'b0};
        for (int k = 0; k < 10; k++)
            repeat (p) sq.push_back(f[k]);
    endfunction

    function automatic void model_edge(input logic v, input logic [31:0] d);
        logic take = v && (mq.size() < 4);
        if (sq.size() != 0) void'(sq.pop_front());
        if (sq.size() == 0) begin
            if (left != 0) begin
                gen_byte(cur_w[8*(4-left) +: 8]);
                left--;
            end else if (mq.size() != 0) begin
                cur_w = mq.pop_front();
                gen_byte(cur_w[7:0]);
                left = 3;
            end
        end
        if (take) mq.push_back(d);
    endfunction

    task automatic step(input logic v, input logic [31:0] d);
        word_valid_i = v;
        word_data_i  = d;
        if (v && word_ready_o) acc++;
        @(posedge clk_i);
        model_edge(v, d);
        #1;
        check("tx", tx_o, (sq.size() != 0) ? sq[0] : 1'b1);
        check("busy", busy_o, sq.size() != 0);
        check("byte_done", byte_done_o, sq.size() == 1);
        check("word_done", word_done_o, sq.size() == 1 && left == 0);
        check("count", fifo_count_o, mq.size());
        check("ready", word_ready_o, mq.size() < 4);
        busy_cyc += busy_o;
        bd_cnt   += byte_done_o;
        wd_cnt   += word_done_o;
    endtask

    task automatic clr();
        busy_cyc = 0; bd_cnt = 0; wd_cnt = 0; acc = 0;
    endtask

    task automatic reset_mid();
        word_valid_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        check("rst_tx", tx_o, 1);
        check("rst_count", fifo_count_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ready", word_ready_o, 1);
        mq.delete(); sq.delete(); left = 0;
        @(posedge clk_i);
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        @(posedge clk_i);
        #1;
        check("init_tx", tx_o, 1);
        check("init_busy", busy_o, 0);
        check("init_count", fifo_count_o, 0);
        check("init_ready", word_ready_o, 1);
        check("init_done", {byte_done_o, word_done_o}, 0);
        #2 rst_ni = 1'b1;
        @(posedge clk_i);
        #1;
        clr();
        cpb = 15'd4;
        step(1'b1, 32'hA5C30F81);
        repeat (200) step(1'b0, '0);
        check("t1_busy", busy_cyc, 160);
        check("t1_bytes", bd_cnt, 4);
        check("t1_words", wd_cnt, 1);
        clr();
        repeat (6) step(1'b1, $urandom);
        check("t2_accepted", acc, 5);
        repeat (900) step(1'b0, '0);
        check("t2_busy", busy_cyc, 800);
        check("t2_words", wd_cnt, 5);
        clr();
        cpb = 15'd0;
        step(1'b1, 32'h000000FF);
        repeat (100) step(1'b0, '0);
        check("t3_busy", busy_cyc, 80);
        clr();
        cpb = 15'd4;
        step(1'b1, $urandom);
        repeat (19) step(1'b0, '0);
        cpb = 15'd8;
        repeat (320) step(1'b0, '0);
        check("t4_busy", busy_cyc, 280);
        cpb = 15'd4;
        repeat (3) step(1'b1, $urandom);
        repeat (48) step(1'b0, '0);
        check("t5_pre_count", fifo_count_o, 2);
        reset_mid();
        clr();
        repeat (200) step(1'b0, '0);
        check("t5_busy_after", busy_cyc, 0);
        for (int i = 0; i < 3000; i++) begin
            if (i % 97 == 0) cpb = 15'($urandom_range(0, 6));
            step($urandom_range(0, 3) == 0, $urandom);
        end
        repeat (1500) step(1'b0, '0);
        check("drain_idle", busy_o, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
